// File: rtl/noc_params.sv
// Router-wide network parameters shared by the switch allocator and its arbiters.
package noc_params;

    localparam int PORT_NUM    = 5;
    localparam int VC_NUM      = 2;
    localparam int VC_SIZE     = $clog2(VC_NUM);
    localparam int BUFFER_SIZE = 8;
    localparam int CREDIT_SIZE = $clog2(BUFFER_SIZE + 1);

    typedef logic [$clog2(PORT_NUM)-1:0] port_t;

endpackage

// File: rtl/separable_switch_allocator_round_robin_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
// The pointer moves past the granted index only when update_en says the grant was used.
module round_robin_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] request,
    input  logic         update_en,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic [PW-1:0] gidx;
    logic          found;

    // Scan requests in rotated order starting at the pointer; first hit wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && request[idx]) begin
                grant[idx] = 1'b1;
                gidx       = idx;
                found      = 1'b1;
            end
        end
    end

    // Advance the pointer to one past the winner when the grant is committed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (update_en && found) begin
            ptr <= PW'((int'(gidx) + 1) % N);
        end
    end

endmodule

// File: rtl/separable_switch_allocator.sv
// Separable input-first switch allocator: per-input VC arbitration, then per-output
// input arbitration, gated by per-output/per-downstream-VC credit counters.
module separable_switch_allocator
    import noc_params::*;
#(
    parameter int BUFFER_SIZE = noc_params::BUFFER_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [VC_NUM-1:0]   switch_request [PORT_NUM],
    input  port_t               out_port       [PORT_NUM][VC_NUM],
    input  logic [VC_SIZE-1:0]  downstream_vc  [PORT_NUM][VC_NUM],
    input  logic [PORT_NUM-1:0] credit_valid,
    input  logic [VC_SIZE-1:0]  credit_vc      [PORT_NUM],
    output logic [VC_SIZE-1:0]  vc_sel         [PORT_NUM],
    output logic [PORT_NUM-1:0] valid_sel,
    output port_t               xb_in_port     [PORT_NUM],
    output logic [PORT_NUM-1:0] xb_valid,
    output logic                credit_error
);

    localparam int             CW         = $clog2(BUFFER_SIZE + 1);
    localparam logic [CW-1:0]  CREDIT_MAX = CW'(BUFFER_SIZE);

    logic [CW-1:0]       credit   [PORT_NUM][VC_NUM];
    logic [VC_NUM-1:0]   eligible [PORT_NUM];
    logic [VC_NUM-1:0]   in_gnt   [PORT_NUM];
    logic [VC_SIZE-1:0]  cand     [PORT_NUM];
    port_t               target   [PORT_NUM];
    logic [PORT_NUM-1:0] has_cand;
    logic [PORT_NUM-1:0] out_req  [PORT_NUM];
    logic [PORT_NUM-1:0] out_gnt  [PORT_NUM];
    port_t               win_port [PORT_NUM];
    logic [PORT_NUM-1:0] out_busy;
    logic [PORT_NUM-1:0] win;
    logic [VC_NUM-1:0]   dec      [PORT_NUM];
    logic [VC_NUM-1:0]   inc      [PORT_NUM];

    // A VC may compete only if its downstream buffer has at least one free slot.
    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                eligible[i][v] = 1'b0;
                if (switch_request[i][v] && (int'(out_port[i][v]) < PORT_NUM)) begin
                    eligible[i][v] = (credit[out_port[i][v]][downstream_vc[i][v]] != '0);
                end
            end
        end
    end

    // Stage 1 and stage 2 arbiters; pointers only move for grants that survive both stages.
    for (genvar g = 0; g < PORT_NUM; g++) begin : g_arb
        round_robin_arbiter #(.N(VC_NUM)) u_in_arb (
            .clk       (clk),
            .rst       (rst),
            .request   (eligible[g]),
            .update_en (win[g]),
            .grant     (in_gnt[g])
        );
        round_robin_arbiter #(.N(PORT_NUM)) u_out_arb (
            .clk       (clk),
            .rst       (rst),
            .request   (out_req[g]),
            .update_en (out_busy[g]),
            .grant     (out_gnt[g])
        );
    end

    // Decode stage-1 winners, build stage-2 requests and decode stage-2 winners.
    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            has_cand[i] = |in_gnt[i];
            cand[i]     = '0;
            for (int v = 0; v < VC_NUM; v++) begin
                if (in_gnt[i][v]) cand[i] = VC_SIZE'(v);
            end
            target[i] = out_port[i][cand[i]];
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                out_req[o][i] = has_cand[i] && (int'(target[i]) == o);
            end
        end
        for (int i = 0; i < PORT_NUM; i++) win[i] = 1'b0;
        for (int o = 0; o < PORT_NUM; o++) begin
            out_busy[o] = |out_gnt[o];
            win_port[o] = '0;
            for (int i = 0; i < PORT_NUM; i++) begin
                if (out_gnt[o][i]) begin
                    win_port[o] = port_t'(i);
                    win[i]      = 1'b1;
                end
            end
        end
    end

    // Grant outputs are combinational and held at zero while reset is asserted.
    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            valid_sel[i]  = rst && win[i];
            vc_sel[i]     = (rst && win[i]) ? cand[i] : '0;
            xb_valid[i]   = rst && out_busy[i];
            xb_in_port[i] = (rst && out_busy[i]) ? win_port[i] : '0;
        end
    end

    // Per-counter decrement (committed grant) and increment (returned credit) strobes.
    always_comb begin
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                dec[o][v] = 1'b0;
                inc[o][v] = credit_valid[o] && (credit_vc[o] == VC_SIZE'(v));
            end
        end
        for (int i = 0; i < PORT_NUM; i++) begin
            if (win[i]) dec[target[i]][downstream_vc[i][cand[i]]] = 1'b1;
        end
    end

    // Credit counters: a return into a full, non-decremented counter saturates and flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_error <= 1'b0;
            for (int o = 0; o < PORT_NUM; o++) begin
                for (int v = 0; v < VC_NUM; v++) credit[o][v] <= CREDIT_MAX;
            end
        end else begin
            for (int o = 0; o < PORT_NUM; o++) begin
                for (int v = 0; v < VC_NUM; v++) begin
                    if (dec[o][v] && !inc[o][v]) begin
                        credit[o][v] <= credit[o][v] - CW'(1);
                    end else if (inc[o][v] && !dec[o][v]) begin
                        if (credit[o][v] == CREDIT_MAX) credit_error <= 1'b1;
                        else                            credit[o][v] <= credit[o][v] + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_separable_switch_allocator.sv
// Bench for separable_switch_allocator: directed scenarios plus randomized traffic,
// all compared against a rule-level reference model of the allocator.
module tb_separable_switch_allocator;
    import noc_params::*;

    logic                clk;
    logic                rst;
    logic [VC_NUM-1:0]   switch_request [PORT_NUM];
    port_t               out_port       [PORT_NUM][VC_NUM];
    logic [VC_SIZE-1:0]  downstream_vc  [PORT_NUM][VC_NUM];
    logic [PORT_NUM-1:0] credit_valid;
    logic [VC_SIZE-1:0]  credit_vc      [PORT_NUM];
    logic [VC_SIZE-1:0]  vc_sel         [PORT_NUM];
    logic [PORT_NUM-1:0] valid_sel;
    port_t               xb_in_port     [PORT_NUM];
    logic [PORT_NUM-1:0] xb_valid;
    logic                credit_error;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_in_ptr  [PORT_NUM];
    int m_out_ptr [PORT_NUM];
    int m_credit  [PORT_NUM][VC_NUM];
    bit m_err;
    // Reference model per-cycle results
    int cand [PORT_NUM];
    int tgt  [PORT_NUM];
    int e_valid [PORT_NUM];
    int e_vc    [PORT_NUM];
    int e_xbv   [PORT_NUM];
    int e_xbp   [PORT_NUM];

    separable_switch_allocator #(.BUFFER_SIZE(BUFFER_SIZE)) dut (
        .clk            (clk),
        .rst            (rst),
        .switch_request (switch_request),
        .out_port       (out_port),
        .downstream_vc  (downstream_vc),
        .credit_valid   (credit_valid),
        .credit_vc      (credit_vc),
        .vc_sel         (vc_sel),
        .valid_sel      (valid_sel),
        .xb_in_port     (xb_in_port),
        .xb_valid       (xb_valid),
        .credit_error   (credit_error)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_vc_sel();
        logic [31:0] r = '0;
        for (int i = 0; i < PORT_NUM; i++) r = r | (32'(vc_sel[i]) << (i * VC_SIZE));
        return r;
    endfunction

    function automatic logic [31:0] pack_xb_port();
        logic [31:0] r = '0;
        for (int o = 0; o < PORT_NUM; o++) r = r | (32'(xb_in_port[o]) << (o * $bits(port_t)));
        return r;
    endfunction

    task automatic model_reset();
        m_err = 1'b0;
        for (int p = 0; p < PORT_NUM; p++) begin
            m_in_ptr[p]  = 0;
            m_out_ptr[p] = 0;
            for (int v = 0; v < VC_NUM; v++) m_credit[p][v] = BUFFER_SIZE;
        end
    endtask

    // Allocation rules: first eligible VC from the input pointer, then first
    // contending input from the output pointer.
    task automatic model_eval();
        for (int i = 0; i < PORT_NUM; i++) begin
            cand[i] = -1;
            tgt[i]  = 0;
            for (int k = 0; k < VC_NUM; k++) begin
                int v = (m_in_ptr[i] + k) % VC_NUM;
                if (cand[i] < 0 && switch_request[i][v] &&
                    m_credit[int'(out_port[i][v])][int'(downstream_vc[i][v])] > 0) begin
                    cand[i] = v;
                    tgt[i]  = int'(out_port[i][v]);
                end
            end
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            e_xbv[o] = 0;
            e_xbp[o] = 0;
            for (int k = 0; k < PORT_NUM; k++) begin
                int i = (m_out_ptr[o] + k) % PORT_NUM;
                if (e_xbv[o] == 0 && cand[i] >= 0 && tgt[i] == o) begin
                    e_xbv[o] = 1;
                    e_xbp[o] = i;
                end
            end
        end
        for (int i = 0; i < PORT_NUM; i++) begin
            e_valid[i] = (cand[i] >= 0 && e_xbv[tgt[i]] == 1 && e_xbp[tgt[i]] == i) ? 1 : 0;
            e_vc[i]    = e_valid[i] ? cand[i] : 0;
        end
    endtask

    task automatic model_step();
        int delta [PORT_NUM][VC_NUM];
        bit ret   [PORT_NUM][VC_NUM];
        for (int o = 0; o < PORT_NUM; o++)
            for (int v = 0; v < VC_NUM; v++) begin
                delta[o][v] = 0;
                ret[o][v]   = 0;
            end
        for (int i = 0; i < PORT_NUM; i++) begin
            if (e_valid[i] != 0) begin
                m_in_ptr[i]       = (cand[i] + 1) % VC_NUM;
                m_out_ptr[tgt[i]] = (i + 1) % PORT_NUM;
                delta[tgt[i]][int'(downstream_vc[i][cand[i]])] -= 1;
            end
        end
        for (int o = 0; o < PORT_NUM; o++)
            if (credit_valid[o]) ret[o][int'(credit_vc[o])] = 1;
        for (int o = 0; o < PORT_NUM; o++)
            for (int v = 0; v < VC_NUM; v++) begin
                if (ret[o][v] && delta[o][v] == 0 && m_credit[o][v] == BUFFER_SIZE) m_err = 1'b1;
                else m_credit[o][v] += delta[o][v] + (ret[o][v] ? 1 : 0);
            end
    endtask

    // Compare all DUT outputs to the model for the current inputs, then clock once.
    task automatic cycle();
        logic [31:0] ev, evc, exv, exp_p;
        #1;
        model_eval();
        ev = '0; evc = '0; exv = '0; exp_p = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            ev    = ev    | (32'(e_valid[i]) << i);
            evc   = evc   | (32'(e_vc[i])    << (i * VC_SIZE));
            exv   = exv   | (32'(e_xbv[i])   << i);
            exp_p = exp_p | (32'(e_xbp[i])   << (i * $bits(port_t)));
        end
        check("valid_sel",    32'(valid_sel), ev);
        check("vc_sel",       pack_vc_sel(),  evc);
        check("xb_valid",     32'(xb_valid),  exv);
        check("xb_in_port",   pack_xb_port(), exp_p);
        check("credit_error", 32'(credit_error), 32'(m_err));
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        credit_valid = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            switch_request[p] = '0;
            credit_vc[p]      = '0;
            for (int v = 0; v < VC_NUM; v++) begin
                out_port[p][v]      = '0;
                downstream_vc[p][v] = '0;
            end
        end
    endtask

    // Assert reset asynchronously, check outputs are forced low, release at next negedge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_valid_sel",  32'(valid_sel), 0);
        check("rst_xb_valid",   32'(xb_valid), 0);
        check("rst_vc_sel",     pack_vc_sel(), 0);
        check("rst_xb_in_port", pack_xb_port(), 0);
        check("rst_credit_err", 32'(credit_error), 0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    // Input 0 VC0 -> output 2 downstream VC0: eight grants fit, the ninth is blocked.
    task automatic exhaust_check(input string tag);
        clear_inputs();
        switch_request[0][0] = 1'b1;
        out_port[0][0]       = port_t'(2);
        for (int n = 0; n < BUFFER_SIZE; n++) begin
            #1 check({tag, "_grant"}, 32'(valid_sel[0]), 1);
            cycle();
        end
        #1 check({tag, "_blocked"}, 32'(valid_sel[0]), 0);
        check({tag, "_blocked_xb"}, 32'(xb_valid[2]), 0);
    endtask

    initial begin
        int exp_w [4] = '{1, 3, 1, 3};
        int exp_v [4] = '{0, 1, 0, 1};
        rst = 1'b0;
        clear_inputs();
        model_reset();

        // Reset with every request high: outputs must be zero, grants appear on release.
        #3;
        for (int p = 0; p < PORT_NUM; p++) begin
            switch_request[p] = '1;
            for (int v = 0; v < VC_NUM; v++) out_port[p][v] = port_t'($urandom_range(0, PORT_NUM - 1));
        end
        do_reset();
        #1 check("release_grant", 32'(|valid_sel), 1);
        cycle();

        // Single request, same-cycle grant.
        do_reset();
        clear_inputs();
        switch_request[0][1] = 1'b1;
        out_port[0][1]       = port_t'(2);
        #1;
        check("single_valid", 32'(valid_sel[0]), 1);
        check("single_vc",    32'(vc_sel[0]), 1);
        check("single_xbv",   32'(xb_valid[2]), 1);
        check("single_xbp",   32'(xb_in_port[2]), 0);
        cycle();

        // Output conflict (inputs 1,3 -> output 4) and intra-input VC alternation (input 2).
        do_reset();
        clear_inputs();
        switch_request[1][0] = 1'b1; out_port[1][0] = port_t'(4); downstream_vc[1][0] = 1'b0;
        switch_request[3][0] = 1'b1; out_port[3][0] = port_t'(4); downstream_vc[3][0] = 1'b1;
        switch_request[2]    = '1;
        out_port[2][0] = port_t'(0); downstream_vc[2][0] = 1'b0;
        out_port[2][1] = port_t'(0); downstream_vc[2][1] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #1;
            check("conflict_winner", 32'(xb_in_port[4]), 32'(exp_w[n]));
            check("intra_vc",        32'(vc_sel[2]),     32'(exp_v[n]));
            cycle();
        end

        // Credit exhaustion, return, and simultaneous grant + return on a counter at 1.
        do_reset();
        exhaust_check("exh");
        credit_valid[2] = 1'b1;
        credit_vc[2]    = 1'b0;
        cycle();
        credit_valid = '0;
        #1 check("after_return", 32'(valid_sel[0]), 1);
        cycle();
        credit_valid[2] = 1'b1;
        #1 check("zero_masked", 32'(valid_sel[0]), 0);
        cycle();
        #1 check("grant_and_return", 32'(valid_sel[0]), 1);
        cycle();
        credit_valid = '0;
        #1 check("still_one", 32'(valid_sel[0]), 1);
        cycle();
        #1 check("now_empty", 32'(valid_sel[0]), 0);
        cycle();

        // Overflow into a full counter, then reset mid-burst restores full credits.
        do_reset();
        clear_inputs();
        credit_valid[3] = 1'b1;
        credit_vc[3]    = 1'b1;
        cycle();
        credit_valid = '0;
        #1 check("overflow_flag", 32'(credit_error), 1);
        cycle();
        switch_request[0][0] = 1'b1;
        out_port[0][0]       = port_t'(2);
        for (int n = 0; n < 3; n++) cycle();
        #2;
        do_reset();
        exhaust_check("post_rst");
        cycle();

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            for (int p = 0; p < PORT_NUM; p++) begin
                switch_request[p] = VC_NUM'($urandom_range(0, (1 << VC_NUM) - 1));
                for (int v = 0; v < VC_NUM; v++) begin
                    out_port[p][v]      = port_t'($urandom_range(0, PORT_NUM - 1));
                    downstream_vc[p][v] = VC_SIZE'($urandom_range(0, VC_NUM - 1));
                end
                credit_vc[p]    = VC_SIZE'($urandom_range(0, VC_NUM - 1));
                credit_valid[p] = ($urandom_range(0, 2) == 0);
                if (credit_valid[p] && m_credit[p][int'(credit_vc[p])] == BUFFER_SIZE &&
                    $urandom_range(0, 39) != 0)
                    credit_valid[p] = 1'b0;
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
